hamming_decoder: RTL
====================

HAMMING_DECODER -- requirements
Module: hamming_decoder

Interface
REQ-001 Parameter COUNT_W, default 16, width of each error-event counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 hc_in  input  12  codeword from hamming_encoder: {d7..d4, p3, d3..d1, p2, d0, p1, p0} in bits 11..0, i.e. bit k = Hamming position k+1.
REQ-005 in_valid  input  1  hc_in is valid this cycle.
REQ-006 in_ready  output  1  decoder accepts hc_in this cycle.
REQ-007 data_out  output  8  decoded data byte.
REQ-008 out_valid  output  1  data_out and the flags are valid.
REQ-009 out_ready  input  1  downstream accepts the output.
REQ-010 err_corrected  output  1  single-bit error found and corrected in this word.
REQ-011 err_detected  output  1  uncorrectable error: syndrome 13..15.
REQ-012 syndrome_out  output  4  raw syndrome of this word.
REQ-013 cnt_clr  input  1  synchronous clear of both counters.
REQ-014 corr_cnt  output  COUNT_W  count of corrected words delivered.
REQ-015 uncorr_cnt  output  COUNT_W  count of uncorrectable words delivered.

Function
REQ-016 Syndrome s0 = XOR of the bits at positions 1,3,5,7,9,11; s1 = positions 2,3,6,7,10,11; s2 = positions 4,5,6,7,12; s3 = positions 8,9,10,11,12; syndrome = {s3,s2,s1,s0}.
REQ-017 Syndrome 0: data passes unchanged; both flags are 0.
REQ-018 Syndrome 1..12: the decoder inverts position s, extracts the data, and sets err_corrected=1. This includes parity positions 1, 2, 4 and 8, where the data is unchanged but the flag is still set.
REQ-019 Syndrome 13..15: the decoder sets err_detected=1, leaves the codeword uncorrected, and outputs the raw data bits.
REQ-020 err_corrected and err_detected are never both 1.
REQ-021 The block is a two-stage pipeline.
  - Stage 1 registers hc_in and the syndrome.
  - Stage 2 registers data_out, the flags and syndrome_out.
REQ-022 A word is accepted on in_valid && in_ready. out_valid rises 2 cycles later if unstalled.
REQ-023 Throughput is one word per cycle while out_ready=1.
REQ-024 Each stage holds its contents while its downstream stage is full and not advancing.
REQ-025 in_ready = !s1_valid || stage 1 advances this cycle; no combinational path from in_valid to in_ready.
REQ-026 While out_valid=1 and out_ready=0, all outputs stay stable.
REQ-027 A word is never dropped or duplicated under any in_valid/out_ready pattern.
REQ-028 corr_cnt increments on out_valid && out_ready && err_corrected. uncorr_cnt increments on out_valid && out_ready && err_detected.
REQ-029 Counters saturate at all-ones and do not wrap.
REQ-030 cnt_clr has priority over a coincident increment: the counter becomes 0.

Reset
REQ-031 While rst=1, all of the following are 0: both valid bits, data_out, both flags, syndrome_out and both counters. in_ready is 1.
REQ-032 Words in flight when reset is asserted are discarded. The first acceptance occurs in the first rising edge after rst deasserts.

Structure
REQ-033 A shared package holds the following constants: CW_W=12, DATA_W=8, SYN_W=4, the parity position masks, and the data-position map for positions 3,5,6,7,9,10,11,12.
REQ-034 The syndrome/correct logic lives in one combinational sub-module, hamming_syndrome; hamming_decoder holds the pipeline and the counters.

Verification
REQ-035 Clean word: hc_in=0xA27 -> data_out=0xA5, syndrome 0, both flags 0, latency 2 cycles.
REQ-036 Single-bit errors:
  - 0xA67 (position 7 flipped) -> data_out=0xA5, syndrome 7, err_corrected=1, corr_cnt=1.
  - 0xAA7 (p3 flipped) -> data_out=0xA5, syndrome 8, err_corrected=1.
REQ-037 Uncorrectable: 0x226 (positions 1 and 12 flipped) -> syndrome 13, err_detected=1, data_out=0x25, uncorr_cnt increments.
REQ-038 Backpressure: stream 8 words with out_ready toggling randomly -> output sequence equals input sequence, in_ready drops only when both stages are full, outputs stable while stalled.
REQ-039 Counters and reset:
  - Force 2^COUNT_W+3 corrected words -> corr_cnt saturates at all-ones.
  - cnt_clr coincident with an increment -> counter reads 0.
  - Assert rst with two words in flight -> out_valid=0 immediately and no stale word appears after release.

Source files
------------

// File: rtl/hamming_decoder_pkg.sv
// Shared constants and helpers for the (12,8) Hamming decoder.
// Codeword bit k holds Hamming position k+1.
package hamming_decoder_pkg;

   localparam int unsigned CW_W   = 12;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned SYN_W  = 4;

   // Highest syndrome that names a real codeword position.
   localparam logic [SYN_W-1:0] SYN_MAX_CORR = 4'd12;

   // Parity-check masks; entry i covers every position whose index has bit i set.
   localparam logic [SYN_W-1:0][CW_W-1:0] PAR_MASK = {
      12'hF80,   // s3: positions 8..12
      12'h878,   // s2: positions 4,5,6,7,12
      12'h666,   // s1: positions 2,3,6,7,10,11
      12'h555    // s0: positions 1,3,5,7,9,11
   };

   // Hamming position carrying data bit i.
   localparam logic [DATA_W-1:0][3:0] DATA_POS = {
      4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3
   };

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              corrected;
      logic              detected;
      logic [SYN_W-1:0]  syndrome;
   } dec_word_t;

   function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
      logic [DATA_W-1:0] d;
      d = '0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         d[i] = cw[DATA_POS[i] - 4'd1];
      end
      return d;
   endfunction

endpackage

// File: rtl/hamming_decoder_if.sv
// Stream, status and counter signals of the Hamming decoder.
// slave = decoder side, master = producer/consumer side.
interface hamming_decoder_if
   import hamming_decoder_pkg::*;
#(
   parameter int unsigned COUNT_W = 16
);

   logic [CW_W-1:0]    hc_in;
   logic               in_valid;
   logic               in_ready;
   logic [DATA_W-1:0]  data_out;
   logic               out_valid;
   logic               out_ready;
   logic               err_corrected;
   logic               err_detected;
   logic [SYN_W-1:0]   syndrome_out;
   logic               cnt_clr;
   logic [COUNT_W-1:0] corr_cnt;
   logic [COUNT_W-1:0] uncorr_cnt;

   modport slave (
      input  hc_in, in_valid, out_ready, cnt_clr,
      output in_ready, data_out, out_valid, err_corrected, err_detected,
             syndrome_out, corr_cnt, uncorr_cnt
   );

   modport master (
      output hc_in, in_valid, out_ready, cnt_clr,
      input  in_ready, data_out, out_valid, err_corrected, err_detected,
             syndrome_out, corr_cnt, uncorr_cnt
   );

endinterface

// File: rtl/hamming_syndrome.sv
// Combinational syndrome generation (ahead of stage 1) and correction /
// data extraction (between stage 1 and stage 2).
module hamming_syndrome
   import hamming_decoder_pkg::*;
(
   input  logic [CW_W-1:0]  i_cw,
   output logic [SYN_W-1:0] o_syndrome,
   input  logic [CW_W-1:0]  i_s1_cw,
   input  logic [SYN_W-1:0] i_s1_syndrome,
   output dec_word_t        o_word
);

   logic            w_corr;
   logic            w_det;
   logic [CW_W-1:0] w_flip;

   always_comb begin
      o_syndrome = '0;
      for (int unsigned i = 0; i < SYN_W; i++) begin
         o_syndrome[i] = ^(i_cw & PAR_MASK[i]);
      end
   end

   always_comb begin
      w_corr = (i_s1_syndrome != '0) && (i_s1_syndrome <= SYN_MAX_CORR);
      w_det  = (i_s1_syndrome > SYN_MAX_CORR);
      w_flip = '0;
      if (w_corr) begin
         w_flip = CW_W'(1) << (i_s1_syndrome - 4'd1);
      end
      // Uncorrectable words leave w_flip at zero, so raw data bits pass through.
      o_word.data      = extract_data(i_s1_cw ^ w_flip);
      o_word.corrected = w_corr;
      o_word.detected  = w_det;
      o_word.syndrome  = i_s1_syndrome;
   end

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage pipelined (12,8) Hamming decoder with valid/ready handshakes
// and saturating corrected/uncorrectable event counters.
module hamming_decoder
   import hamming_decoder_pkg::*;
#(
   parameter int unsigned COUNT_W = 16
)
(
   input  logic             clk,
   input  logic             rst,
   hamming_decoder_if.slave bus
);

   logic                 r_s1_valid;
   logic [CW_W-1:0]      r_s1_cw;
   logic [SYN_W-1:0]     r_s1_syn;
   logic                 r_s2_valid;
   dec_word_t            r_s2_word;
   logic [COUNT_W-1:0]   r_corr_cnt;
   logic [COUNT_W-1:0]   r_uncorr_cnt;

   logic [SYN_W-1:0]     w_syn;
   dec_word_t            w_word;
   logic                 w_s2_load;
   logic                 w_in_ready;
   logic                 w_out_fire;

   hamming_syndrome u_syndrome (
      .i_cw          (bus.hc_in),
      .o_syndrome    (w_syn),
      .i_s1_cw       (r_s1_cw),
      .i_s1_syndrome (r_s1_syn),
      .o_word        (w_word)
   );

   // Ready depends only on registered state and out_ready, never on in_valid.
   assign w_s2_load  = !r_s2_valid || bus.out_ready;
   assign w_in_ready = !r_s1_valid || w_s2_load;
   assign w_out_fire = r_s2_valid && bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_cw    <= '0;
         r_s1_syn   <= '0;
      end else if (w_in_ready) begin
         r_s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_s1_cw  <= bus.hc_in;
            r_s1_syn <= w_syn;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_word  <= '0;
      end else if (w_s2_load) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_word <= w_word;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_corr_cnt   <= '0;
         r_uncorr_cnt <= '0;
      end else if (bus.cnt_clr) begin
         r_corr_cnt   <= '0;
         r_uncorr_cnt <= '0;
      end else if (w_out_fire) begin
         if (r_s2_word.corrected && (r_corr_cnt != '1)) begin
            r_corr_cnt <= r_corr_cnt + 1'b1;
         end
         if (r_s2_word.detected && (r_uncorr_cnt != '1)) begin
            r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
         end
      end
   end

   assign bus.in_ready      = w_in_ready;
   assign bus.out_valid     = r_s2_valid;
   assign bus.data_out      = r_s2_word.data;
   assign bus.err_corrected = r_s2_word.corrected;
   assign bus.err_detected  = r_s2_word.detected;
   assign bus.syndrome_out  = r_s2_word.syndrome;
   assign bus.corr_cnt      = r_corr_cnt;
   assign bus.uncorr_cnt    = r_uncorr_cnt;

endmodule
